// File: rtl/kyber_pkg.sv
// Shared constants for the Kyber polynomial-arithmetic blocks: modulus, widths,
// basemul sequencing parameters and the controller state encoding.
package kyber_pkg;
  localparam int          COEF_W    = 12;
  localparam int          ADDR_W    = 7;
  localparam int          N_PAIRS   = 128;
  localparam logic [11:0] KQ        = 12'd3329;
  localparam logic [6:0]  ZETA_BASE = 7'd64;
  localparam logic [6:0]  K_LAST    = 7'd127;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READ   = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;
endpackage

// File: rtl/mod_q_neg.sv
// Modular negation q - x for a reduced coefficient; zero stays zero so the
// result is always in [0, q-1].
module mod_q_neg
  import kyber_pkg::*;
(
  input  logic [COEF_W-1:0] x,
  output logic [COEF_W-1:0] y
);

  // Negate modulo q with the zero special case.
  always_comb begin
    if (x == 12'd0) begin
      y = 12'd0;
    end else begin
      y = KQ - x;
    end
  end

endmodule

// File: rtl/poly_basemul_ctrl.sv
// Walks the 128 coefficient pairs of an NTT-domain product through one basemul
// core: fetch a[k], b[k], zeta; run the core; write r[k] back in ascending order.
module poly_basemul_ctrl
  import kyber_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_rd_en,
  output logic [6:0]  o_rd_addr,
  input  logic [23:0] i_a_rdata,
  input  logic [23:0] i_b_rdata,
  output logic [6:0]  o_zeta_addr,
  input  logic [11:0] i_zeta,
  output logic        o_bm_en,
  output logic [11:0] o_bm_p_h,
  output logic [11:0] o_bm_p_l,
  output logic [11:0] o_bm_q_h,
  output logic [11:0] o_bm_q_l,
  output logic [11:0] o_bm_zeta,
  input  logic        i_bm_done,
  input  logic [11:0] i_bm_r_h,
  input  logic [11:0] i_bm_r_l,
  output logic        o_wr_en,
  output logic [6:0]  o_wr_addr,
  output logic [23:0] o_wr_data
);

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic [6:0]  k;
  logic [6:0]  k_nx;
  logic [11:0] zeta_neg;
  logic [11:0] zeta_sel;

  mod_q_neg u_neg (
    .x (i_zeta),
    .y (zeta_neg)
  );

  // Odd pairs use the negated twiddle of their even neighbour.
  always_comb begin
    if (k[0]) begin
      zeta_sel = zeta_neg;
    end else begin
      zeta_sel = i_zeta;
    end
  end

  // Next-state and pair-counter logic.
  always_comb begin
    state_nx = state;
    k_nx     = k;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_nx = ST_READ;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_READ:  state_nx = ST_LOAD;
      ST_LOAD:  state_nx = ST_RUN;
      ST_RUN: begin
        if (i_bm_done) begin
          state_nx = ST_WRITE;
        end else begin
          state_nx = ST_RUN;
        end
      end
      ST_WRITE: begin
        if (k == K_LAST) begin
          state_nx = ST_FINISH;
        end else begin
          state_nx = ST_READ;
          k_nx     = k + 7'd1;
        end
      end
      ST_FINISH: begin
        state_nx = ST_IDLE;
        k_nx     = 7'd0;
      end
      default: begin
        state_nx = ST_IDLE;
        k_nx     = 7'd0;
      end
    endcase
  end

  // State, counter and registered outputs; strobes are decoded from the next state.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= ST_IDLE;
      k           <= 7'd0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_rd_en     <= 1'b0;
      o_rd_addr   <= 7'd0;
      o_zeta_addr <= 7'd0;
      o_bm_en     <= 1'b0;
      o_bm_p_h    <= 12'd0;
      o_bm_p_l    <= 12'd0;
      o_bm_q_h    <= 12'd0;
      o_bm_q_l    <= 12'd0;
      o_bm_zeta   <= 12'd0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= 7'd0;
      o_wr_data   <= 24'd0;
    end else begin
      state   <= state_nx;
      k       <= k_nx;
      o_busy  <= (state_nx != ST_IDLE);
      o_done  <= (state_nx == ST_FINISH);
      o_rd_en <= (state_nx == ST_READ);
      o_bm_en <= (state_nx == ST_RUN);
      o_wr_en <= (state == ST_RUN) && i_bm_done;
      if (state_nx == ST_READ) begin
        o_rd_addr   <= k_nx;
        o_zeta_addr <= ZETA_BASE + {1'b0, k_nx[6:1]};
      end
      // Operands are only loaded here, so they stay frozen for the whole multiply.
      if (state == ST_LOAD) begin
        o_bm_p_h  <= i_a_rdata[23:12];
        o_bm_p_l  <= i_a_rdata[11:0];
        o_bm_q_h  <= i_b_rdata[23:12];
        o_bm_q_l  <= i_b_rdata[11:0];
        o_bm_zeta <= zeta_sel;
      end
      if ((state == ST_RUN) && i_bm_done) begin
        o_wr_addr <= k;
        o_wr_data <= {i_bm_r_h, i_bm_r_l};
      end
    end
  end

endmodule
